div32_iter: RTL and testbench

//   Multi-cycle integer divider for the M-extension datapath. It is the

---
 rtl/div32_iter.sv | 160 ++++++++++++++++
 tb/tb_div32_iter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/div32_iter.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One trial subtraction per clock; o_busy stalls the pipeline while it runs.
// Build option: define DIV32_FAST_EN to skip the iteration loop when the
// divisor magnitude exceeds the dividend magnitude (same results, lower latency).
module div32_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0] OneExt = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_quot;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;       // divisor magnitude
  logic [CntW-1:0]  r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_special;   // r_quot/r_rem already hold the final raw result
  logic             r_dbz_pend;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_quot_o;
  logic [WIDTH-1:0] r_rem_o;
  logic             r_dbz;

  // Operand magnitudes and special-case detection at start
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_dvs_zero;
  logic             w_ovf;
  logic             w_fast;

  assign w_dvd_neg  = i_signed & i_dividend[WIDTH-1];
  assign w_dvs_neg  = i_signed & i_divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign w_dvs_mag  = w_dvs_neg ? (~i_divisor + 1'b1) : i_divisor;
  assign w_dvs_zero = (i_divisor == '0);
  assign w_ovf      = i_signed && (i_dividend == MinNeg) && (&i_divisor);

`ifdef DIV32_FAST_EN
  assign w_fast = (w_dvs_mag > w_dvd_mag);
`else
  assign w_fast = 1'b0;
`endif

  // One restoring step: shift {rem,quot} left, trial-subtract at WIDTH+1 bits
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_rem_sh = {r_rem, r_quot[WIDTH-1]};
  assign w_diff   = w_rem_sh + {1'b1, ~r_dvs} + OneExt;
  assign w_ge     = ~w_diff[WIDTH];

  // Sign fix-up applied in the final state (skipped for special cases)
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_quot_fix = (!r_special && r_neg_q) ? (~r_quot + 1'b1) : r_quot;
  assign w_rem_fix  = (!r_special && r_neg_r) ? (~r_rem + 1'b1) : r_rem;

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_quot_o   <= '0;
      r_rem_o    <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // r_busy is still high in the o_valid cycle, so a start there is dropped
          r_busy <= 1'b0;
          if (i_start && !r_busy) begin
            r_busy     <= 1'b1;
            r_dvs      <= w_dvs_mag;
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_cnt      <= '0;
            r_dbz_pend <= w_dvs_zero;
            if (w_dvs_zero) begin
              r_quot    <= '1;
              r_rem     <= i_dividend;
              r_special <= 1'b1;
              r_state   <= StFix;
            end else if (w_ovf) begin
              r_quot    <= i_dividend;
              r_rem     <= '0;
              r_special <= 1'b1;
              r_state   <= StFix;
            end else if (w_fast) begin
              r_quot    <= '0;
              r_rem     <= i_dividend;
              r_special <= 1'b1;
              r_state   <= StFix;
            end else begin
              r_quot    <= w_dvd_mag;
              r_rem     <= '0;
              r_special <= 1'b0;
              r_state   <= StCalc;
            end
          end
        end
        StCalc: begin
          r_quot <= {r_quot[WIDTH-2:0], w_ge};
          r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LastStep) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_quot_o <= w_quot_fix;
          r_rem_o  <= w_rem_fix;
          r_dbz    <= r_dbz_pend;
          r_valid  <= 1'b1;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_valid       = r_valid;
  assign o_quot        = r_quot_o;
  assign o_rem         = r_rem_o;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div32_iter.sv
// Directed self-checking bench for div32_iter (default WIDTH=32).
module tb_div32_iter;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_quot;
  logic [31:0] o_rem;
  logic        o_div_by_zero;

  int checks;
  int failures;

`ifdef DIV32_FAST_EN
  localparam int FastLat = 2;
`else
  localparam int FastLat = 34;
`endif

  div32_iter #(.WIDTH(32)) u_dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_signed     (i_signed),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_quot       (o_quot),
    .o_rem        (o_rem),
    .o_div_by_zero(o_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Start one division at a negedge; inputs are scrambled after the start cycle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input int elat, input logic start_at_valid);
    int n;
    @(negedge clk);
    i_start    = 1'b1;
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    @(negedge clk);
    i_start    = 1'b0;
    i_dividend = ~a;
    i_divisor  = b ^ 32'h0000_5a5a;
    n = 1;
    check_eq({tag, ".busy1"}, 32'(o_busy), 32'd1);
    while (!o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, ".lat"}, 32'(n), 32'(elat));
    check_eq({tag, ".q"}, o_quot, eq);
    check_eq({tag, ".r"}, o_rem, er);
    check_eq({tag, ".dbz"}, 32'(o_div_by_zero), 32'(edbz));
    check_eq({tag, ".busyv"}, 32'(o_busy), 32'd1);
    if (start_at_valid) begin
      i_start    = 1'b1;
      i_dividend = 32'd9;
      i_divisor  = 32'd3;
    end
    @(negedge clk);
    i_start = 1'b0;
    check_eq({tag, ".pulse"}, 32'(o_valid), 32'd0);
    check_eq({tag, ".idle"}, 32'(o_busy), 32'd0);
    check_eq({tag, ".qhold"}, o_quot, eq);
  endtask

  initial begin
    int vcount;
    checks     = 0;
    failures   = 0;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.busy", 32'(o_busy), 32'd0);
    check_eq("rst.valid", 32'(o_valid), 32'd0);
    check_eq("rst.q", o_quot, 32'd0);
    check_eq("rst.r", o_rem, 32'd0);
    check_eq("rst.dbz", 32'(o_div_by_zero), 32'd0);
    i_reset = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b0);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 1'b0);
    run_div("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 34,
            1'b0);
    run_div("uFFFF_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 34, 1'b0);
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 1'b1);
    run_div("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 1'b0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 2, 1'b0);
    run_div("u3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, FastLat, 1'b0);
    run_div("s-3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b0, FastLat, 1'b0);
    // Unsigned: 0x80000000 / 0xFFFFFFFF is an ordinary division, not overflow
    run_div("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, FastLat,
            1'b0);

    // Abort: start, ignored re-start at cycle 5, reset at cycle 10
    @(negedge clk);
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'hFFFF_FFFF;
    i_divisor  = 32'd1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      i_start = (n == 5);
      if (n == 5) begin
        i_dividend = 32'd3;
        i_divisor  = 32'd1;
      end
      if (n == 10) i_reset = 1'b1;
      if (n == 11) begin
        check_eq("abort.busy", 32'(o_busy), 32'd0);
        check_eq("abort.q", o_quot, 32'd0);
        check_eq("abort.r", o_rem, 32'd0);
        check_eq("abort.valid", 32'(o_valid), 32'd0);
        i_reset = 1'b0;
      end
    end
    vcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_valid) vcount++;
    end
    check_eq("abort.novalid", 32'(vcount), 32'd0);
    run_div("restart", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
